// File: rtl/rdm_input_buffer_writer.sv
// rdm_input_buffer_writer: packs demapped LLR symbols into 768-bit words
// and fills the ping-pong input buffer read by the rate-dematching FSM.
module rdm_input_buffer_writer #(
   parameter int NUM_BANKS = 2,
   parameter int ADDR_W    = 10
) (
   input  logic              i_core_clk,
   input  logic              i_rx_rstn,
   input  logic              i_rx_fsm_rstn,
   input  logic              i_start,
   input  logic [ADDR_W+3:0] i_Current_Combine_E01_Size,
   input  logic [31:0]       i_users_qm,
   input  logic [3:0]        i_Combine_user_index,
   input  logic              i_sym_valid,
   input  logic [47:0]       i_sym_data,
   output logic              o_sym_ready,
   output logic              o_wr_en,
   output logic [ADDR_W:0]   o_wr_addr,
   output logic [767:0]      o_wr_data,
   input  logic              i_RDM_Data_Comp,
   output logic              o_Combine_process_request,
   output logic              o_rd_bank,
   output logic              o_busy
);

   localparam int         CNT_W = ADDR_W + 4;
   localparam logic [1:0] FULL  = 2'(NUM_BANKS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_COLLECT = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   logic             rst_n;
   logic [2:0]       state;
   logic [CNT_W-1:0] e01;
   logic [CNT_W-1:0] sym_cnt;
   logic [3:0]       qm;
   logic [3:0]       qm_field;
   logic [3:0]       qm_lim;
   logic [47:0]      lanes;
   logic [767:0]     pack;
   logic [767:0]     word;
   logic [3:0]       slot;
   logic             wbank;
   logic [1:0]       occ;
   logic             comp_q;
   logic             comp_rise;
   logic             fill;
   logic             accept;
   logic             last;

   assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

   assign o_sym_ready = (state == S_COLLECT);
   assign o_busy      = (state != S_IDLE);

   assign slot      = sym_cnt[3:0];
   assign accept    = i_sym_valid & o_sym_ready;
   assign last      = (sym_cnt == e01);
   assign comp_rise = i_RDM_Data_Comp & ~comp_q;
   assign fill      = (state == S_FLUSH) & ~o_wr_en;

   // User indices 8..15 have no qm field and read as qm=0.
   always_comb begin
      qm_field = '0;
      if (!i_Combine_user_index[3])
         qm_field = i_users_qm[{i_Combine_user_index[2:0], 2'b00} +: 4];
      qm_lim = (qm_field > 4'd8) ? 4'd8 : qm_field;
   end

   always_comb begin
      lanes = '0;
      for (int j = 0; j < 8; j++) begin
         if (4'(j) < qm)
            lanes[6*j +: 6] = i_sym_data[6*j +: 6];
      end
   end

   always_comb begin
      word = pack;
      word[48*slot +: 48] = lanes;
   end

   always_ff @(posedge i_core_clk or negedge rst_n) begin
      if (!rst_n) begin
         state                     <= S_IDLE;
         e01                       <= '0;
         qm                        <= '0;
         sym_cnt                   <= '0;
         pack                      <= '0;
         wbank                     <= 1'b0;
         o_wr_en                   <= 1'b0;
         o_wr_addr                 <= '0;
         o_wr_data                 <= '0;
         o_Combine_process_request <= 1'b0;
      end else begin
         o_wr_en                   <= 1'b0;
         o_Combine_process_request <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  e01     <= i_Current_Combine_E01_Size;
                  qm      <= qm_lim;
                  sym_cnt <= '0;
                  pack    <= '0;
                  state   <= (occ < FULL) ? S_COLLECT : S_WAIT;
               end
            end
            S_WAIT: begin
               if (occ < FULL)
                  state <= S_COLLECT;
            end
            S_COLLECT: begin
               if (accept) begin
                  if (slot == 4'hF || last) begin
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= {wbank, sym_cnt[CNT_W-1:4]};
                     o_wr_data <= word;
                     pack      <= '0;
                  end else begin
                     pack <= word;
                  end
                  if (last)
                     state <= S_FLUSH;
                  else
                     sym_cnt <= sym_cnt + 1'b1;
               end
            end
            S_FLUSH: begin
               // Final word strobe has gone out; hand the bank over.
               if (!o_wr_en) begin
                  wbank                     <= ~wbank;
                  o_Combine_process_request <= 1'b1;
                  state                     <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_core_clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= '0;
         comp_q    <= 1'b0;
         o_rd_bank <= 1'b0;
      end else begin
         comp_q <= i_RDM_Data_Comp;
         if (fill && !comp_rise)
            occ <= occ + 2'd1;
         else if (!fill && comp_rise && occ != 2'd0)
            occ <= occ - 2'd1;
         if (comp_rise && (occ != 2'd0 || fill))
            o_rd_bank <= ~o_rd_bank;
      end
   end

endmodule

// File: tb/tb_rdm_input_buffer_writer.sv
// tb_rdm_input_buffer_writer: random and directed blocks checked against
// a per-symbol model of word layout, bank ping-pong and occupancy.
module tb_rdm_input_buffer_writer;

   logic         clk = 1'b0;
   logic         rstn;
   logic         fsm_rstn;
   logic         start;
   logic [13:0]  e01_in;
   logic [31:0]  users_in;
   logic [3:0]   uidx_in;
   logic         sym_valid;
   logic [47:0]  sym_data;
   logic         sym_ready;
   logic         wr_en;
   logic [10:0]  wr_addr;
   logic [767:0] wr_data;
   logic         comp;
   logic         req;
   logic         rd_bank;
   logic         busy;

   rdm_input_buffer_writer dut (
      .i_core_clk                 (clk),
      .i_rx_rstn                  (rstn),
      .i_rx_fsm_rstn              (fsm_rstn),
      .i_start                    (start),
      .i_Current_Combine_E01_Size (e01_in),
      .i_users_qm                 (users_in),
      .i_Combine_user_index       (uidx_in),
      .i_sym_valid                (sym_valid),
      .i_sym_data                 (sym_data),
      .o_sym_ready                (sym_ready),
      .o_wr_en                    (wr_en),
      .o_wr_addr                  (wr_addr),
      .o_wr_data                  (wr_data),
      .i_RDM_Data_Comp            (comp),
      .o_Combine_process_request  (req),
      .o_rd_bank                  (rd_bank),
      .o_busy                     (busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [10:0]  addr_q [$];
   logic [767:0] data_q [$];
   int           req_q  [$];

   logic [47:0] syms [0:127];

   int cur_e01;
   int cur_qm;
   bit cur_bank;
   bit blk_wait;
   int mocc;
   bit mwb;
   bit mrd;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         addr_q.push_back(wr_addr);
         data_q.push_back(wr_data);
      end
      if (req)
         req_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [767:0] got,
                      input logic [767:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int model_qm(input logic [31:0] u, input int idx);
      int f;
      if (idx >= 8) return 0;
      f = int'((u >> (4*idx)) & 32'hF);
      return (f > 8) ? 8 : f;
   endfunction

   function automatic logic [767:0] exp_word(input int w);
      logic [767:0] d;
      int i;
      d = '0;
      for (int s = 0; s < 16; s++) begin
         i = w*16 + s;
         if (i <= cur_e01) begin
            for (int j = 0; j < 8; j++)
               if (j < cur_qm) d[48*s + 6*j +: 6] = syms[i][6*j +: 6];
         end
      end
      return d;
   endfunction

   task automatic rel_model();
      if (mocc > 0) begin
         mocc--;
         mrd = ~mrd;
      end
   endtask

   task automatic release_bank();
      comp = 1'b1;
      rel_model();
      @(negedge clk);
      chk("rd_bank_release", rd_bank, mrd);
      comp = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_syms(input bit rnd, input int n);
      for (int i = 0; i < n; i++)
         syms[i] = rnd ? {16'($urandom), 32'($urandom)}
                       : {42'h3FF_FFFF_FFFF, 6'(i)};
   endtask

   task automatic start_blk(input int e01, input logic [31:0] users,
                            input logic [3:0] uidx);
      cur_e01  = e01;
      cur_qm   = model_qm(users, int'(uidx));
      cur_bank = mwb;
      blk_wait = (mocc >= 2);
      addr_q.delete();
      data_q.delete();
      req_q.delete();
      e01_in   = 14'(e01);
      users_in = users;
      uidx_in  = uidx;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      e01_in   = 14'($urandom);
      users_in = $urandom;
      uidx_in  = 4'($urandom);
      chk("busy_start", busy, 1'b1);
      chk("ready_start", sym_ready, !blk_wait);
   endtask

   task automatic feed(input int n, input bit gaps, output int first,
                       output int last, output bit ok);
      int idx = 0;
      int budget = 0;
      bit took = 0;
      first = -1;
      last = -1;
      while (idx < n && budget < 3000) begin
         if (took) sym_valid = 1'b0;
         if (!sym_valid)
            sym_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         sym_data = syms[idx];
         took = sym_valid && sym_ready;
         if (took) begin
            if (first < 0) first = cyc;
            last = cyc;
            idx++;
         end
         @(negedge clk);
         budget++;
      end
      ok = (idx == n);
   endtask

   task automatic finish_blk(input bit gaps, input bit sim_rel);
      int first, last, ecnt;
      bit ok;
      if (blk_wait) begin
         sym_valid = 1'b1;
         sym_data  = syms[0];
         repeat (3) begin
            @(negedge clk);
            chk("wait_ready", sym_ready, 1'b0);
         end
         comp = 1'b1;
         rel_model();
         @(negedge clk);
         chk("rd_bank_wait_rel", rd_bank, mrd);
         chk("wait_ready_lag", sym_ready, 1'b0);
         comp = 1'b0;
         @(negedge clk);
         chk("resume_ready", sym_ready, 1'b1);
      end
      feed(cur_e01 + 1, gaps, first, last, ok);
      chk("feed_timeout", ok, 1'b1);
      sym_valid = 1'b0;
      chk("ready_drop", sym_ready, 1'b0);
      @(negedge clk);
      if (sim_rel) begin
         comp = 1'b1;
         if (mocc > 0 || 1) mrd = ~mrd;
      end
      @(negedge clk);
      if (sim_rel) begin
         comp = 1'b0;
         chk("rd_bank_simul", rd_bank, mrd);
      end
      chk("busy_done", busy, 1'b1);
      @(negedge clk);
      chk("busy_idle", busy, 1'b0);
      if (!sim_rel) mocc++;
      mwb = ~mwb;
      chk("req_count", req_q.size(), 1);
      if (req_q.size() > 0) chk("req_cycle", req_q[0], last + 3);
      ecnt = cur_e01 / 16 + 1;
      chk("wr_count", addr_q.size(), ecnt);
      for (int w = 0; w < addr_q.size() && w < ecnt; w++) begin
         chk("wr_addr", addr_q[w], {cur_bank, 10'(w)});
         chk("wr_data", data_q[w], exp_word(w));
      end
      if (ok && !gaps) chk("full_rate", last - first, cur_e01);
   endtask

   initial begin
      bit ok;
      int f, l;
      rstn = 1'b0; fsm_rstn = 1'b1; start = 1'b0;
      e01_in = '0; users_in = '0; uidx_in = '0;
      sym_valid = 1'b0; sym_data = '0; comp = 1'b0;
      mocc = 0; mwb = 0; mrd = 0;
      repeat (3) @(negedge clk);
      chk("rst_ready", sym_ready, 1'b0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 11'd0);
      chk("rst_wr_data", wr_data, 768'd0);
      chk("rst_req", req, 1'b0);
      chk("rst_rd_bank", rd_bank, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rstn = 1'b1;
      @(negedge clk);

      // basic pack, full rate
      fill_syms(0, 32);
      start_blk(31, 32'h0000_0002, 4'd0);
      finish_blk(0, 0);
      if (data_q.size() == 2) begin
         chk("basic_pos5", data_q[0][48*5 +: 48], 48'hFC5);
         chk("basic_pos16", data_q[1][0 +: 48], 48'hFD0);
      end
      release_bank();

      // partial final word
      fill_syms(1, 21);
      start_blk(20, 32'h0000_0008, 4'd0);
      finish_blk(1, 0);
      if (data_q.size() == 2)
         chk("partial_hi_zero", data_q[1][767:240], 528'd0);
      release_bank();

      // ping-pong backpressure
      for (int b = 0; b < 3; b++) begin
         fill_syms(1, 16);
         start_blk(15, $urandom, 4'($urandom_range(0, 7)));
         finish_blk(0, 0);
      end
      if (addr_q.size() > 0) chk("bp_bank0", addr_q[0][10], 1'b0);
      release_bank();

      // release coincides with fill: occupancy stays at 1
      fill_syms(1, 17);
      start_blk(16, 32'h7777_7777, 4'd2);
      finish_blk(0, 1);
      fill_syms(1, 6);
      start_blk(5, 32'h5555_5555, 4'd1);
      finish_blk(1, 0);
      fill_syms(1, 6);
      start_blk(5, 32'h1234_5678, 4'd4);
      finish_blk(1, 0);

      // qm edge cases
      fill_syms(1, 36);
      start_blk(35, 32'h8888_8888, 4'd9);
      finish_blk(1, 0);
      for (int w = 0; w < data_q.size(); w++)
         chk("qm0_zero", data_q[w], 768'd0);
      fill_syms(1, 18);
      start_blk(17, 32'h0000_C000, 4'd3);
      finish_blk(0, 0);
      if (data_q.size() > 0)
         chk("qm12_all", data_q[0][47:0], syms[0]);

      // reset mid-block
      while (mocc > 0) release_bank();
      if (!mrd) begin
         fill_syms(1, 4);
         start_blk(3, 32'h1, 4'd0);
         finish_blk(0, 0);
         release_bank();
      end
      fill_syms(1, 41);
      start_blk(40, 32'h8, 4'd0);
      feed(10, 0, f, l, ok);
      chk("mid_feed", ok, 1'b1);
      sym_valid = 1'b0;
      fsm_rstn  = 1'b0;
      #1;
      chk("mid_ready", sym_ready, 1'b0);
      chk("mid_wr_en", wr_en, 1'b0);
      chk("mid_wr_addr", wr_addr, 11'd0);
      chk("mid_wr_data", wr_data, 768'd0);
      chk("mid_req", req, 1'b0);
      chk("mid_rd_bank", rd_bank, 1'b0);
      chk("mid_busy", busy, 1'b0);
      @(negedge clk);
      fsm_rstn = 1'b1;
      mocc = 0; mwb = 0; mrd = 0;
      repeat (8) @(negedge clk);
      chk("mid_no_req", req_q.size(), 0);
      chk("mid_no_wr", addr_q.size(), 0);

      // randomized blocks
      for (int b = 0; b < 25; b++) begin
         int e;
         e = $urandom_range(0, 79);
         if (mocc > 0 && ($urandom % 2) == 1) release_bank();
         fill_syms(1, e + 1);
         start_blk(e, $urandom, 4'($urandom_range(0, 15)));
         finish_blk($urandom % 2 == 1, ($urandom % 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
